rx_stat_arbiter: RTL and testbench

RX_STAT_ARBITER -- requirements
Module: rx_stat_arbiter

---
 rtl/rx_stat_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_rx_stat_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_stat_arbiter.sv
// rx_stat_arbiter
//   Collects one-cycle event pulses from NUM_SRC sources into small pending
//   counts and drains them, one at a time in round-robin order, into a bank
//   of saturating CNT_W-bit statistics counters. A host read port shares the
//   same single-cycle update slot and takes priority over draining.
//
// Ports
//   x_clk          clock, all logic on its rising edge
//   reset_         asynchronous active-low reset
//   stat_en        synchronous enable; low clears all statistics state
//   ev_req         per-source one-cycle event pulses
//   hst_rd_req     host read request, held until hst_rd_vld
//   hst_addr       counter index to read
//   hst_clr_on_rd  clear the addressed counter as it is read
//   hst_rd_data    read data, valid while hst_rd_vld is high
//   hst_rd_vld     one-cycle read-data-valid strobe
//   ev_drop        sticky per-source lost-event flag
//   arb_busy       FSM active or events still pending
module rx_stat_arbiter #(
  parameter int NUM_SRC = 8,
  parameter int CNT_W   = 32,
  parameter int AW      = 3
) (
  input  logic               x_clk,
  input  logic               reset_,
  input  logic               stat_en,
  input  logic [NUM_SRC-1:0] ev_req,
  input  logic               hst_rd_req,
  input  logic [AW-1:0]      hst_addr,
  input  logic               hst_clr_on_rd,
  output logic [CNT_W-1:0]   hst_rd_data,
  output logic               hst_rd_vld,
  output logic [NUM_SRC-1:0] ev_drop,
  output logic               arb_busy
);

  typedef enum logic [1:0] {IDLE, UPD, HRD} state_t;

  localparam logic [AW:0] NSRC = (AW+1)'(NUM_SRC);

  state_t           state, state_nxt;
  logic [1:0]       pend [NUM_SRC];
  logic [CNT_W-1:0] cnt  [NUM_SRC];
  logic [AW-1:0]    rr_ptr, grant, rd_addr;
  logic             rd_clr;
  logic [AW-1:0]    rr_pick, rr_next;
  logic [AW:0]      rr_sum;
  logic             rr_found;
  logic             host_take, upd_take;
  logic             upd_fire, hrd_fire;
  logic             addr_ok;
  logic [NUM_SRC-1:0] svc;

  // Round-robin search: walk the sources starting at rr_ptr, wrapping at
  // NUM_SRC, and pick the first one with a nonzero pending count. rr_found
  // doubles as "anything pending".
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    rr_sum   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      rr_sum = {1'b0, rr_ptr} + (AW+1)'(k);
      if (rr_sum >= NSRC) rr_sum = rr_sum - NSRC;
      if (!rr_found && pend[rr_sum[AW-1:0]] != 2'd0) begin
        rr_found = 1'b1;
        rr_pick  = rr_sum[AW-1:0];
      end
    end
    rr_next = (({1'b0, rr_pick} + 1'b1) >= NSRC) ? '0 : rr_pick + 1'b1;
  end

  // State register.
  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic. A host read is only accepted when the previous read's
  // strobe is not showing, so a request still held during hst_rd_vld is not
  // mistaken for a second read.
  always_comb begin
    state_nxt = state;
    host_take = 1'b0;
    upd_take  = 1'b0;
    if (!stat_en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (hst_rd_req && !hst_rd_vld) begin
            host_take = 1'b1;
            state_nxt = HRD;
          end else if (rr_found) begin
            upd_take  = 1'b1;
            state_nxt = UPD;
          end
        end
        UPD:     state_nxt = IDLE;
        HRD:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode.
  always_comb begin
    upd_fire = stat_en && (state == UPD);
    hrd_fire = stat_en && (state == HRD);
    arb_busy = (state != IDLE) || rr_found;
    addr_ok  = ({1'b0, rd_addr} < NSRC);
    svc      = '0;
    if (upd_fire) svc[grant] = 1'b1;
  end

  // Latched grant / host command and the round-robin pointer.
  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      rr_ptr  <= '0;
      grant   <= '0;
      rd_addr <= '0;
      rd_clr  <= 1'b0;
    end else if (!stat_en) begin
      rr_ptr <= '0;
    end else begin
      if (host_take) begin
        rd_addr <= hst_addr;
        rd_clr  <= hst_clr_on_rd;
      end
      if (upd_take) begin
        grant  <= rr_pick;
        rr_ptr <= rr_next;
      end
    end
  end

  // Pending counts: an event and a service in the same cycle cancel out.
  // A new event hitting a full count is lost and flagged.
  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_SRC; i++) pend[i] <= 2'd0;
      ev_drop <= '0;
    end else if (!stat_en) begin
      for (int i = 0; i < NUM_SRC; i++) pend[i] <= 2'd0;
      ev_drop <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        case ({ev_req[i], svc[i]})
          2'b10: begin
            if (pend[i] == 2'd3) ev_drop[i] <= 1'b1;
            else                 pend[i]    <= pend[i] + 2'd1;
          end
          2'b01:   pend[i] <= pend[i] - 2'd1;
          default: ;
        endcase
      end
    end
  end

  // Statistics counters: saturating increment on UPD, optional clear on a
  // host read. Events still pending for a cleared counter are counted later.
  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else if (!stat_en) begin
      for (int i = 0; i < NUM_SRC; i++) cnt[i] <= '0;
    end else if (upd_fire) begin
      if (cnt[grant] != '1) cnt[grant] <= cnt[grant] + 1'b1;
    end else if (hrd_fire && rd_clr && addr_ok) begin
      cnt[rd_addr] <= '0;
    end
  end

  // Host read data path; out-of-range addresses read as zero.
  always_ff @(posedge x_clk or negedge reset_) begin
    if (!reset_) begin
      hst_rd_data <= '0;
      hst_rd_vld  <= 1'b0;
    end else begin
      hst_rd_vld <= hrd_fire;
      if (hrd_fire) hst_rd_data <= addr_ok ? cnt[rd_addr] : '0;
    end
  end

endmodule

// File: tb/tb_rx_stat_arbiter.sv
// tb_rx_stat_arbiter
//   Scoreboarded bench for rx_stat_arbiter. Instance "a" uses the default
//   parameters; instance "b" uses NUM_SRC=6, CNT_W=4 so counter saturation
//   and out-of-range host addresses can be exercised. Host reads push their
//   hand-computed expected data into a per-instance queue; a monitor pops
//   and compares whenever hst_rd_vld is seen.
module tb_rx_stat_arbiter;

  logic       x_clk;
  logic       reset_;
  logic       stat_en;

  logic [7:0] ev_req_a;
  logic       hst_rd_req_a;
  logic [2:0] hst_addr_a;
  logic       hst_clr_on_rd_a;
  logic [31:0] hst_rd_data_a;
  logic       hst_rd_vld_a;
  logic [7:0] ev_drop_a;
  logic       arb_busy_a;

  logic [5:0] ev_req_b;
  logic       hst_rd_req_b;
  logic [2:0] hst_addr_b;
  logic       hst_clr_on_rd_b;
  logic [3:0] hst_rd_data_b;
  logic       hst_rd_vld_b;
  logic [5:0] ev_drop_b;
  logic       arb_busy_b;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  rx_stat_arbiter #(.NUM_SRC(8), .CNT_W(32), .AW(3)) dut_a (
    .x_clk(x_clk), .reset_(reset_), .stat_en(stat_en),
    .ev_req(ev_req_a), .hst_rd_req(hst_rd_req_a), .hst_addr(hst_addr_a),
    .hst_clr_on_rd(hst_clr_on_rd_a), .hst_rd_data(hst_rd_data_a),
    .hst_rd_vld(hst_rd_vld_a), .ev_drop(ev_drop_a), .arb_busy(arb_busy_a)
  );

  rx_stat_arbiter #(.NUM_SRC(6), .CNT_W(4), .AW(3)) dut_b (
    .x_clk(x_clk), .reset_(reset_), .stat_en(stat_en),
    .ev_req(ev_req_b), .hst_rd_req(hst_rd_req_b), .hst_addr(hst_addr_b),
    .hst_clr_on_rd(hst_clr_on_rd_b), .hst_rd_data(hst_rd_data_b),
    .hst_rd_vld(hst_rd_vld_b), .ev_drop(ev_drop_b), .arb_busy(arb_busy_b)
  );

  initial x_clk = 1'b0;
  always #5 x_clk = ~x_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_cmp++;
    if (actual !== expected) begin
      n_mis++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge x_clk);
      #1;
    end
  endtask

  // One-cycle event pulse on the chosen instance.
  task automatic applyStimulus(input bit inst, input logic [7:0] ev);
    if (!inst) ev_req_a = ev;
    else       ev_req_b = ev[5:0];
    tick(1);
    ev_req_a = '0;
    ev_req_b = '0;
  endtask

  // Full host read: queue the expected data, hold the request until the
  // strobe appears, then drop it in the strobe cycle.
  task automatic hostRead(input bit inst, input logic [2:0] addr,
                          input bit clr, input logic [31:0] exp_data);
    bit got = 1'b0;
    if (!inst) begin
      qa.push_back(exp_data);
      hst_rd_req_a = 1'b1; hst_addr_a = addr; hst_clr_on_rd_a = clr;
    end else begin
      qb.push_back(exp_data);
      hst_rd_req_b = 1'b1; hst_addr_b = addr; hst_clr_on_rd_b = clr;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      tick(1);
      if (!inst ? hst_rd_vld_a : hst_rd_vld_b) got = 1'b1;
    end
    hst_rd_req_a = 1'b0; hst_clr_on_rd_a = 1'b0;
    hst_rd_req_b = 1'b0; hst_clr_on_rd_b = 1'b0;
    if (!got) begin
      n_cmp++;
      n_mis++;
      $display("[TB] FAIL read_timeout inst=%0d addr=%0d: no hst_rd_vld, expected within 20 cycles",
               inst, addr);
      if (!inst) void'(qa.pop_back());
      else       void'(qb.pop_back());
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge x_clk) begin
    if (hst_rd_vld_a) begin
      if (qa.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("[TB] FAIL vld_a_unexpected: got hst_rd_vld=1 data=%0d, expected no strobe",
                 hst_rd_data_a);
      end else begin
        checkOutput("rd_data_a", hst_rd_data_a, qa.pop_front());
      end
    end
    if (hst_rd_vld_b) begin
      if (qb.size() == 0) begin
        n_cmp++;
        n_mis++;
        $display("[TB] FAIL vld_b_unexpected: got hst_rd_vld=1 data=%0d, expected no strobe",
                 hst_rd_data_b);
      end else begin
        checkOutput("rd_data_b", {28'd0, hst_rd_data_b}, qb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_ = 1'b0; stat_en = 1'b1;
    ev_req_a = '0; hst_rd_req_a = 1'b0; hst_addr_a = '0; hst_clr_on_rd_a = 1'b0;
    ev_req_b = '0; hst_rd_req_b = 1'b0; hst_addr_b = '0; hst_clr_on_rd_b = 1'b0;
    #2;
    checkOutput("reset_vld",  hst_rd_vld_a,  0);
    checkOutput("reset_data", hst_rd_data_a, 0);
    checkOutput("reset_drop", ev_drop_a,     0);
    checkOutput("reset_busy", arb_busy_a,    0);
    #10 reset_ = 1'b1;
    tick(2);

    // Single event on source 3, counted three edges later.
    applyStimulus(0, 8'h08);
    checkOutput("busy_pending", arb_busy_a, 1);
    tick(2);
    checkOutput("busy_drained", arb_busy_a, 0);
    hostRead(0, 3'd3, 1'b0, 1);
    hostRead(0, 3'd3, 1'b1, 1);
    hostRead(0, 3'd3, 1'b0, 0);

    // Clear rr_ptr, then an event on every source: grants 0,1,2.. in order.
    stat_en = 1'b0; tick(1); stat_en = 1'b1;
    applyStimulus(0, 8'hFF);
    tick(3);
    // Only sources 0 and 1 have been counted when this read is granted.
    hostRead(0, 3'd2, 1'b0, 0);
    tick(11);
    checkOutput("busy_last_upd", arb_busy_a, 1);
    tick(1);
    checkOutput("busy_all_done", arb_busy_a, 0);
    for (int i = 0; i < 8; i++) hostRead(0, 3'(i), (i == 5), 1);

    // A host read delays draining while source 5 pulses four times.
    tick(2);
    ev_req_a = 8'h20; tick(1);
    qa.push_back(0);
    hst_rd_req_a = 1'b1; hst_addr_a = 3'd5; tick(1);
    tick(1);
    hst_rd_req_a = 1'b0; tick(1);
    ev_req_a = '0;
    checkOutput("drop_set", ev_drop_a, 8'h20);
    tick(4);
    checkOutput("busy_drain5", arb_busy_a, 1);
    tick(1);
    checkOutput("busy_idle5", arb_busy_a, 0);
    hostRead(0, 3'd5, 1'b0, 3);
    checkOutput("drop_sticky", ev_drop_a, 8'h20);
    stat_en = 1'b0; tick(1); stat_en = 1'b1;
    checkOutput("drop_cleared", ev_drop_a, 0);
    hostRead(0, 3'd5, 1'b0, 0);

    // Build cnt[2]=7, then read-with-clear while a new event lands.
    repeat (7) begin
      applyStimulus(0, 8'h04);
      tick(1);
    end
    tick(4);
    qa.push_back(7);
    hst_rd_req_a = 1'b1; hst_addr_a = 3'd2; hst_clr_on_rd_a = 1'b1; tick(1);
    ev_req_a = 8'h04; tick(1);
    checkOutput("clr_read_vld", hst_rd_vld_a, 1);
    ev_req_a = '0; hst_rd_req_a = 1'b0; hst_clr_on_rd_a = 1'b0;
    tick(4);
    hostRead(0, 3'd2, 1'b0, 1);

    // Narrow instance: saturation at 15 and out-of-range addresses.
    repeat (17) begin
      applyStimulus(1, 8'h01);
      tick(1);
    end
    tick(4);
    checkOutput("b_no_drop", ev_drop_b, 0);
    hostRead(1, 3'd0, 1'b0, 15);
    hostRead(1, 3'd7, 1'b1, 0);
    hostRead(1, 3'd6, 1'b0, 0);
    hostRead(1, 3'd0, 1'b0, 15);

    // Reset while source 4 is being updated.
    applyStimulus(0, 8'h10);
    tick(1);
    reset_ = 1'b0;
    #1;
    checkOutput("rst_upd_busy", arb_busy_a,    0);
    checkOutput("rst_upd_data", hst_rd_data_a, 0);
    checkOutput("rst_upd_vld",  hst_rd_vld_a,  0);
    tick(2);
    #3 reset_ = 1'b1;
    tick(3);
    checkOutput("rst_upd_idle", arb_busy_a, 0);
    hostRead(0, 3'd4, 1'b0, 0);
    hostRead(0, 3'd2, 1'b0, 0);
    hostRead(1, 3'd0, 1'b0, 0);

    // Reset while a host read is in HRD: no strobe may follow.
    tick(2);
    hst_rd_req_a = 1'b1; hst_addr_a = 3'd2; tick(1);
    reset_ = 1'b0; hst_rd_req_a = 1'b0;
    #3 reset_ = 1'b1;
    tick(4);
    checkOutput("rst_hrd_idle", arb_busy_a, 0);

    // stat_en low for one cycle drops pending work and ignores the host.
    applyStimulus(0, 8'h03);
    tick(6);
    hostRead(0, 3'd1, 1'b0, 1);
    tick(2);
    applyStimulus(0, 8'h40);
    stat_en = 1'b0; hst_rd_req_a = 1'b1; hst_addr_a = 3'd1; tick(1);
    stat_en = 1'b1; hst_rd_req_a = 1'b0;
    checkOutput("stat_en_busy", arb_busy_a, 0);
    tick(3);
    hostRead(0, 3'd0, 1'b0, 0);
    hostRead(0, 3'd1, 1'b0, 0);
    hostRead(0, 3'd6, 1'b0, 0);

    tick(5);
    checkOutput("qa_drained", qa.size(), 0);
    checkOutput("qb_drained", qb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
